demux_scheduler: RTL and testbench

Registered 1-to-N demultiplexer controller that steers a valid/ready input stream to one of N output channels. In round-robin mode it rotates the destination every `burst_len` accepted words; in fixed mode it routes everything to `cfg_sel`. It sits between a single producer and N consumers, replacing a hand-driven `sel` line with a sequenced, flow-controlled select.

---
 rtl/demux_scheduler.sv | 125 ++++++++++++
 tb/tb_demux_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux_scheduler.sv
// rtl/demux_scheduler.sv - registered 1-to-N stream demux with round-robin / fixed destination select
//
// Steers one valid/ready producer stream into a one-entry buffer whose
// word is presented to exactly one of N consumers.
//
// Ports:
//   clock, reset    : single clock, asynchronous active-high reset
//   in_valid/in_data/in_ready : producer stream (in_ready is combinational)
//   out_valid[N]    : one-hot, bit i set when channel i holds the buffered word
//   out_data        : buffered word, shared by all channels
//   out_ready[N]    : per-channel consumer ready, only the target bit matters
//   mode            : 0 = round-robin, 1 = fixed to cfg_sel
//   cfg_sel         : fixed-mode destination
//   burst_len       : words per channel in round-robin mode (0 behaves as 1)
//   ptr             : current round-robin destination
//   busy            : buffer holds a word

module demux_scheduler #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SW    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [N-1:0]     out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic [N-1:0]     out_ready,
    input  logic             mode,
    input  logic [SW-1:0]    cfg_sel,
    input  logic [3:0]       burst_len,
    output logic [SW-1:0]    ptr,
    output logic             busy
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SW-1:0]    r_tgt;
    logic [SW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_beat_cnt;

    logic             w_drain;
    logic             w_accept;
    logic [3:0]       w_limit_m1;
    logic             w_rr_wrap;

    // Only the ready bit of the channel currently holding the word can drain it.
    always_comb begin
        w_drain  = (r_state == S_FULL) && out_ready[r_tgt];
        w_accept = in_valid && in_ready;
    end

    // A burst length of 0 is folded to 1. Using >= means a burst length
    // lowered beneath the running count advances on the very next accept.
    always_comb begin
        w_limit_m1 = (burst_len == 4'd0) ? 4'd0 : (burst_len - 4'd1);
        w_rr_wrap  = (r_beat_cnt >= w_limit_m1);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: an accept wins over a drain, so a same-cycle
    // drain+accept keeps the buffer FULL with the new word.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = S_FULL;
        end else if (w_drain) begin
            w_state_nxt = S_EMPTY;
        end
    end

    // Output logic
    always_comb begin
        in_ready  = !reset && ((r_state == S_EMPTY) || w_drain);
        busy      = (r_state == S_FULL);
        out_data  = r_data;
        ptr       = r_ptr;
        out_valid = '0;
        for (int i = 0; i < N; i++) begin
            out_valid[i] = (r_state == S_FULL) && (r_tgt == i[SW-1:0]);
        end
    end

    // Buffer and rotation bookkeeping; mode, cfg_sel and burst_len only
    // matter at the moment a word is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data     <= '0;
            r_tgt      <= '0;
            r_ptr      <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_data <= in_data;
            if (mode) begin
                r_tgt      <= cfg_sel;
                r_beat_cnt <= 4'd0;
            end else begin
                r_tgt <= r_ptr;
                if (w_rr_wrap) begin
                    r_beat_cnt <= 4'd0;
                    r_ptr      <= r_ptr + SW'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// tb/tb_demux_scheduler.sv - table-driven self-checking bench for demux_scheduler

module tb_demux_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [3:0] out_ready;
    logic       mode;
    logic [1:0] cfg_sel;
    logic [3:0] burst_len;
    logic [1:0] ptr;
    logic       busy;

    int n_applied = 0;
    int n_miss    = 0;

    demux_scheduler #(.WIDTH(8), .N(4), .SW(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .mode      (mode),
        .cfg_sel   (cfg_sel),
        .burst_len (burst_len),
        .ptr       (ptr),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [7:0] din;
        logic [3:0] rdy;
        logic       md;
        logic [1:0] sel;
        logic [3:0] bl;
        logic       e_ir;
        logic [3:0] e_ov;
        logic [7:0] e_od;
        logic [1:0] e_ptr;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic vld, input logic [7:0] din,
                       input logic [3:0] rdy, input logic md, input logic [1:0] sel,
                       input logic [3:0] bl, input logic e_ir, input logic [3:0] e_ov,
                       input logic [7:0] e_od, input logic [1:0] e_ptr, input logic e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.din = din; v.rdy = rdy; v.md = md; v.sel = sel;
        v.bl = bl; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ptr = e_ptr;
        v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] din, input logic [3:0] rdy,
                         input logic md, input logic [1:0] sel, input logic [3:0] bl);
        in_valid = vld; in_data = din; out_ready = rdy; mode = md; cfg_sel = sel; burst_len = bl;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 4'd1);

        //   rst vld din    rdy    md sel bl    ir  ov     od     ptr  busy
        // round-robin, burst 1, words 0x10..0x15, ptr wraps 3 -> 0
        add(0, 1, 8'h10, 4'hF, 0, 0, 4'd1, 1, 4'b0001, 8'h10, 2'd1, 1);
        add(0, 1, 8'h11, 4'hF, 0, 0, 4'd1, 1, 4'b0010, 8'h11, 2'd2, 1);
        add(0, 1, 8'h12, 4'hF, 0, 0, 4'd1, 1, 4'b0100, 8'h12, 2'd3, 1);
        add(0, 1, 8'h13, 4'hF, 0, 0, 4'd1, 1, 4'b1000, 8'h13, 2'd0, 1);
        add(0, 1, 8'h14, 4'hF, 0, 0, 4'd1, 1, 4'b0001, 8'h14, 2'd1, 1);
        add(0, 1, 8'h15, 4'hF, 0, 0, 4'd1, 1, 4'b0010, 8'h15, 2'd2, 1);
        // drain only: buffer empties, data held
        add(0, 0, 8'h00, 4'hF, 0, 0, 4'd1, 1, 4'b0000, 8'h15, 2'd2, 0);
        add(1, 0, 8'h00, 4'hF, 0, 0, 4'd1, 0, 4'b0000, 8'h00, 2'd0, 0);
        // round-robin, burst 3: channels 0,0,0,1,1,1,2
        add(0, 1, 8'h20, 4'hF, 0, 0, 4'd3, 1, 4'b0001, 8'h20, 2'd0, 1);
        add(0, 1, 8'h21, 4'hF, 0, 0, 4'd3, 1, 4'b0001, 8'h21, 2'd0, 1);
        add(0, 1, 8'h22, 4'hF, 0, 0, 4'd3, 1, 4'b0001, 8'h22, 2'd1, 1);
        add(0, 1, 8'h23, 4'hF, 0, 0, 4'd3, 1, 4'b0010, 8'h23, 2'd1, 1);
        add(0, 1, 8'h24, 4'hF, 0, 0, 4'd3, 1, 4'b0010, 8'h24, 2'd1, 1);
        add(0, 1, 8'h25, 4'hF, 0, 0, 4'd3, 1, 4'b0010, 8'h25, 2'd2, 1);
        add(0, 1, 8'h26, 4'hF, 0, 0, 4'd3, 1, 4'b0100, 8'h26, 2'd2, 1);
        add(0, 0, 8'h00, 4'hF, 0, 0, 4'd3, 1, 4'b0000, 8'h26, 2'd2, 0);
        add(1, 0, 8'h00, 4'hF, 0, 0, 4'd1, 0, 4'b0000, 8'h00, 2'd0, 0);
        // get ptr to 1, then fixed mode to channel 3, then round-robin resumes at 1
        add(0, 1, 8'h30, 4'hF, 0, 0, 4'd1, 1, 4'b0001, 8'h30, 2'd1, 1);
        add(0, 1, 8'h31, 4'hF, 1, 3, 4'd1, 1, 4'b1000, 8'h31, 2'd1, 1);
        add(0, 1, 8'h32, 4'hF, 1, 3, 4'd1, 1, 4'b1000, 8'h32, 2'd1, 1);
        add(0, 1, 8'h33, 4'hF, 1, 3, 4'd1, 1, 4'b1000, 8'h33, 2'd1, 1);
        add(0, 1, 8'h34, 4'hF, 1, 3, 4'd1, 1, 4'b1000, 8'h34, 2'd1, 1);
        add(0, 1, 8'h35, 4'hF, 0, 3, 4'd1, 1, 4'b0010, 8'h35, 2'd2, 1);
        // backpressure on channel 1 for 5 cycles, other ready bits high
        for (int k = 0; k < 5; k++)
            add(0, 1, 8'h36, 4'b1101, 0, 0, 4'd1, 0, 4'b0010, 8'h35, 2'd2, 1);
        // release: drain and accept in the same cycle
        add(0, 1, 8'h36, 4'hF, 0, 0, 4'd1, 1, 4'b0100, 8'h36, 2'd3, 1);
        // burst_len 0 behaves as 1: channels 0,1,2
        add(1, 0, 8'h00, 4'hF, 0, 0, 4'd0, 0, 4'b0000, 8'h00, 2'd0, 0);
        add(0, 1, 8'h40, 4'hF, 0, 0, 4'd0, 1, 4'b0001, 8'h40, 2'd1, 1);
        add(0, 1, 8'h41, 4'hF, 0, 0, 4'd0, 1, 4'b0010, 8'h41, 2'd2, 1);
        add(0, 1, 8'h42, 4'hF, 0, 0, 4'd0, 1, 4'b0100, 8'h42, 2'd3, 1);
        // burst_len lowered below running count advances immediately
        add(0, 1, 8'h43, 4'hF, 0, 0, 4'd3, 1, 4'b1000, 8'h43, 2'd3, 1);
        add(0, 1, 8'h44, 4'hF, 0, 0, 4'd3, 1, 4'b1000, 8'h44, 2'd3, 1);
        add(0, 1, 8'h45, 4'hF, 0, 0, 4'd2, 1, 4'b1000, 8'h45, 2'd0, 1);

        // reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data", 32'(out_data), 32'h0);
        chk("reset ptr", 32'(ptr), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);

        foreach (tbl[i]) begin
            @(negedge clock);
            reset = tbl[i].rst;
            drive(tbl[i].vld, tbl[i].din, tbl[i].rdy, tbl[i].md, tbl[i].sel, tbl[i].bl);
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            @(posedge clock);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("v%0d ptr", i), 32'(ptr), 32'(tbl[i].e_ptr));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
        end

        // asynchronous reset mid-cycle with the buffer FULL on channel 2
        @(negedge clock);
        reset = 1'b1;
        drive(1'b0, 8'h00, 4'hF, 1'b0, 2'd0, 4'd1);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'(8'h50 + k), 4'hF, 1'b0, 2'd0, 4'd1);
            @(negedge clock);
        end
        drive(1'b0, 8'h00, 4'h0, 1'b0, 2'd0, 4'd1);
        @(posedge clock);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'b0100);
        chk("pre-reset busy", 32'(busy), 32'h1);
        chk("pre-reset ptr", 32'(ptr), 32'h3);
        #3;
        reset = 1'b1;
        #1;
        chk("async out_valid", 32'(out_valid), 32'h0);
        chk("async busy", 32'(busy), 32'h0);
        chk("async out_data", 32'(out_data), 32'h0);
        chk("async in_ready", 32'(in_ready), 32'h0);
        out_ready = 4'hF;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        chk("held in_ready", 32'(in_ready), 32'h0);
        chk("held out_valid", 32'(out_valid), 32'h0);
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("post-reset ptr", 32'(ptr), 32'h0);
        chk("post-reset out_valid", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
